// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves B-type / JAL outcomes forwarded from the branch hazard stage,
//   computes the target (pc + imm, wrapping), and on an aligned taken branch
//   issues a redirect to fetch followed by a flush window. Prediction is
//   static not-taken, so every taken branch counts as a mispredict.
// Ports
//   clk, reset           clock (rising edge), async active-low reset
//   br_valid             opcode/funct3/flags/pc/imm valid this cycle
//   opcode, funct3       instruction fields
//   V, C, N, Z, L        compare flags (L = unsigned less-than)
//   pc, imm              branch PC and sign-extended offset
//   redirect_ready       fetch accepts redirect
//   redirect_valid/pc    redirect request and target
//   flush                kill younger instructions in IF/ID
//   busy                 unit cannot accept br_valid
//   resolved/taken       1-cycle evaluation pulse and its outcome
//   misalign             1-cycle pulse: taken target not word aligned
//   cnt_branches/taken   saturating statistics
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             V,
  input  logic             C,
  input  logic             N,
  input  logic             Z,
  input  logic             L,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             busy,
  output logic             resolved,
  output logic             taken,
  output logic             misalign,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_taken
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam int         FCW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  typedef struct packed {
    logic            hit;   // valid branch/JAL presented
    logic            take;
    logic            mis;   // taken target not word aligned
    logic [XLEN-1:0] tgt;
  } dec_t;

  state_t   state;
  logic [FCW-1:0] fcnt;
  dec_t     dec;
  logic     cond;

  // Carry flag is forwarded but no RV32 branch condition needs it.
  logic unused_c;
  assign unused_c = C;

  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      3'b000:  cond = Z;
      3'b001:  cond = ~Z;
      3'b100:  cond = N ^ V;
      3'b101:  cond = ~(N ^ V);
      3'b110:  cond = L;
      3'b111:  cond = ~L;
      default: cond = 1'b0;   // 010/011 are not branch conditions
    endcase
    dec      = '0;
    dec.tgt  = pc + imm;      // wraps modulo 2^XLEN
    dec.hit  = br_valid & ((opcode == OP_BRANCH) | (opcode == OP_JAL));
    dec.take = (opcode == OP_JAL) ? 1'b1 : cond;
    dec.mis  = dec.take & (dec.tgt[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      fcnt           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      resolved       <= 1'b0;
      taken          <= 1'b0;
      misalign       <= 1'b0;
      cnt_branches   <= '0;
      cnt_taken      <= '0;
    end else begin
      resolved <= 1'b0;
      taken    <= 1'b0;
      misalign <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dec.hit) begin
            resolved <= 1'b1;
            taken    <= dec.take;
            if (cnt_branches != '1) cnt_branches <= cnt_branches + 1'b1;
            if (dec.take && cnt_taken != '1) cnt_taken <= cnt_taken + 1'b1;
            if (dec.take) begin
              if (dec.mis) begin
                misalign <= 1'b1;   // report only, fetch is not redirected
              end else begin
                state          <= REDIRECT;
                redirect_valid <= 1'b1;
                redirect_pc    <= dec.tgt;
                flush          <= 1'b1;
                busy           <= 1'b1;
              end
            end
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= FLUSH;
            redirect_valid <= 1'b0;
            fcnt           <= FCW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (fcnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int CW = 8;   // narrow counters so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          reset;
  logic          br_valid;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          V, C, N, Z, L;
  logic [31:0]   pc, imm;
  logic          redirect_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          flush, busy, resolved, taken, misalign;
  logic [CW-1:0] cnt_branches, cnt_taken;

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .opcode(opcode), .funct3(funct3),
    .V(V), .C(C), .N(N), .Z(Z), .L(L), .pc(pc), .imm(imm),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .busy(busy), .resolved(resolved),
    .taken(taken), .misalign(misalign), .cnt_branches(cnt_branches), .cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tk;
    bit          mis;
    bit          rd;
    logic [31:0] tgt;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mb = 0, mt = 0;   // model counters
  localparam int SAT = (1 << CW) - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every resolved pulse is matched against the front entry.
  always @(negedge clk) begin
    if (reset) begin
      if (resolved) begin
        if (sbq.size() == 0) begin
          chk("spurious_resolved", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          mb = (mb < SAT) ? mb + 1 : SAT;
          if (e.tk) mt = (mt < SAT) ? mt + 1 : SAT;
          chk("taken", taken, e.tk);
          chk("misalign", misalign, e.mis);
          chk("redirect_valid", redirect_valid, e.rd);
          if (e.rd) chk("redirect_pc", redirect_pc, e.tgt);
          chk("cnt_branches", 32'(cnt_branches), mb);
          chk("cnt_taken", 32'(cnt_taken), mt);
        end
      end else begin
        chk("taken_wo_resolved", taken, 0);
        chk("misalign_wo_resolved", misalign, 0);
      end
    end
  end

  // Drive one br_valid cycle; idle = bench's belief the unit can accept.
  task automatic drive_br(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] fl,
                          input logic [31:0] p, input logic [31:0] im, input bit idle,
                          output bit redir);
    bit   hit, tk, c;
    logic [31:0] t;
    logic fv, fn, fz, flt;
    fv = fl[4]; fn = fl[2]; fz = fl[1]; flt = fl[0];
    case (f3)
      3'd0: c = fz;
      3'd1: c = !fz;
      3'd4: c = fn != fv;
      3'd5: c = fn == fv;
      3'd6: c = flt;
      3'd7: c = !flt;
      default: c = 0;
    endcase
    hit = (op == 7'b1100011) || (op == 7'b1101111);
    tk  = (op == 7'b1101111) ? 1'b1 : c;
    t   = p + im;
    redir = 0;
    if (idle && hit) begin
      exp_t e;
      e.tk = tk; e.mis = tk && (t % 4 != 0); e.rd = tk && (t % 4 == 0); e.tgt = t;
      redir = e.rd;
      sbq.push_back(e);
    end
    br_valid = 1; opcode = op; funct3 = f3;
    {V, C, N, Z, L} = fl;
    pc = p; imm = im;
    tick();
    br_valid = 0;
    chk("resolve_latency", resolved, idle && hit);
  endtask

  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, ALU = 7'b0110011;
  // flag vector order {V,C,N,Z,L}

  initial begin
    bit rd;
    reset = 0; br_valid = 0; opcode = 0; funct3 = 0;
    {V, C, N, Z, L} = 0; pc = 0; imm = 0; redirect_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resolved", resolved, 0);
    chk("rst_cnt_b", 32'(cnt_branches), 0);
    chk("rst_cnt_t", 32'(cnt_taken), 0);
    reset = 1;
    tick();

    // BEQ taken, ready high: redirect at t+1 then flush for 1+2 cycles
    drive_br(BR, 3'd0, 5'b00010, 32'h100, 32'h20, 1, rd);
    chk("beq_rv", redirect_valid, 1);
    chk("beq_pc", redirect_pc, 32'h120);
    chk("beq_flush0", flush, 1);
    chk("beq_busy0", busy, 1);
    tick();
    chk("beq_rv_drop", redirect_valid, 0);
    chk("beq_flush1", flush, 1);
    tick();
    chk("beq_flush2", flush, 1);
    chk("beq_busy2", busy, 1);
    tick();
    chk("beq_flush_end", flush, 0);
    chk("beq_busy_end", busy, 0);

    // BLT taken then not taken, back to back where possible
    drive_br(BR, 3'd4, 5'b00100, 32'h200, 32'h8, 1, rd);
    repeat (3) tick();
    drive_br(BR, 3'd4, 5'b10100, 32'h200, 32'h8, 1, rd);
    chk("blt_nt_busy", busy, 0);

    // Taken BNE with fetch stalled for 5 cycles
    redirect_ready = 0;
    drive_br(BR, 3'd1, 5'b00000, 32'h400, 32'hFFFF_FF00, 1, rd);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rv", redirect_valid, 1);
      chk("stall_pc", redirect_pc, 32'h300);
      chk("stall_flush", flush, 1);
      chk("stall_busy", busy, 1);
      if (i == 2) drive_br(BR, 3'd0, 5'b00010, 32'h0, 32'h4, 0, rd); // ignored while busy
      else tick();
    end
    redirect_ready = 1;
    tick();
    chk("stall_rv_drop", redirect_valid, 0);
    repeat (2) tick();
    chk("stall_idle", busy, 0);

    // JAL wrap, then misaligned JAL
    drive_br(JAL, 3'd0, 5'b0, 32'hFFFF_FFF0, 32'h20, 1, rd);
    chk("jal_wrap_pc", redirect_pc, 32'h10);
    repeat (3) tick();
    drive_br(JAL, 3'd0, 5'b0, 32'hFFFF_FFF0, 32'h2, 1, rd);
    chk("mis_no_redirect", redirect_valid, 0);
    chk("mis_not_busy", busy, 0);

    // funct3 010 not taken; non-branch opcode ignored
    drive_br(BR, 3'd2, 5'b00010, 32'h40, 32'h4, 1, rd);
    drive_br(ALU, 3'd0, 5'b00010, 32'h40, 32'h4, 1, rd);

    // Random mix
    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      logic [31:0] im;
      case ($urandom_range(0, 3))
        0, 1: op = BR;
        2:    op = JAL;
        default: op = ALU;
      endcase
      im = $urandom();
      if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
      drive_br(op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
               $urandom() & 32'hFFFF_FFFC, im, 1, rd);
      if (rd) repeat (3) tick();
    end

    // Reset asserted during FLUSH
    drive_br(JAL, 3'd0, 5'b0, 32'h1000, 32'h40, 1, rd);
    tick();
    chk("pre_rst_flush", flush, 1);
    #2 reset = 0;
    #1;
    chk("arst_flush", flush, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rv", redirect_valid, 0);
    chk("arst_pc", redirect_pc, 0);
    chk("arst_cnt_b", 32'(cnt_branches), 0);
    mb = 0; mt = 0;
    sbq.delete();
    @(negedge clk);
    reset = 1;
    tick();
    chk("post_rst_busy", busy, 0);

    // Saturation: not-taken branches then misaligned taken ones
    for (int i = 0; i < SAT + 5; i++)
      drive_br(BR, 3'd0, 5'b00000, 32'h80, 32'h4, 1, rd);
    chk("sat_cnt_b", 32'(cnt_branches), SAT);
    for (int i = 0; i < SAT + 5; i++)
      drive_br(JAL, 3'd0, 5'b0, 32'h80, 32'h2, 1, rd);
    tick();
    chk("sat_cnt_t", 32'(cnt_taken), SAT);
    chk("sat_cnt_b_hold", 32'(cnt_branches), SAT);
    chk("sbq_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
